// File: rtl/sram_track_sequencer_pkg.sv
// Shared encodings and the sample-averaging helper for the two-track SRAM recorder.
package sram_track_sequencer_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned TRACK_A_BASE = 0;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2,
    MODE_MIX  = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    StIdle,
    StRecWr,
    StPlayRdA,
    StPlayRdB,
    StPlayOut,
    StMixRdA,
    StMixRdB,
    StMixWr,
    StMixEnd
  } state_e;

  // One extra bit of headroom so the sum never overflows before the arithmetic halving.
  function automatic logic [SAMPLE_W-1:0] avg(input logic [SAMPLE_W-1:0] a,
                                              input logic [SAMPLE_W-1:0] b);
    logic signed [SAMPLE_W:0] sum;
    sum = $signed({a[SAMPLE_W-1], a}) + $signed({b[SAMPLE_W-1], b});
    return sum[SAMPLE_W:1];
  endfunction

endpackage

// File: rtl/sram_track_sequencer_access.sv
// Access timer for the board SRAM: 2-cycle reads, 3-cycle setup/strobe/hold writes.
// All pin controls are registered so an async reset releases the bus immediately.
module sram_access_timer #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iWDATA,
  output logic              oDONE,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_WDATA,
  output logic              oSRAM_DQ_OE,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N
);

  logic              busy_q;
  logic              wr_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dq_oe_q;
  logic              we_n_q;
  logic              oe_n_q;

  // Done marks the last cycle of the access; a new request may start on the same edge.
  assign oDONE = busy_q & (cnt_q == (wr_q ? 2'd2 : 2'd1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else if (iREQ) begin
      busy_q  <= 1'b1;
      wr_q    <= iWR;
      cnt_q   <= 2'd0;
      addr_q  <= iADDR;
      if (iWR) wdata_q <= iWDATA;
      dq_oe_q <= iWR;
      oe_n_q  <= iWR;
      we_n_q  <= 1'b1;
    end else if (busy_q) begin
      if (oDONE) begin
        busy_q  <= 1'b0;
        dq_oe_q <= 1'b0;
        oe_n_q  <= 1'b1;
        we_n_q  <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 2'd1;
        we_n_q <= !(wr_q && (cnt_q == 2'd0));
      end
    end
  end

  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_WDATA = wdata_q;
  assign oSRAM_DQ_OE = dq_oe_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;

endmodule

// File: rtl/sram_track_sequencer.sv
// Sequences record, averaged playback and offline mix accesses to the single board SRAM,
// paced by the codec LR clock.
module sram_track_sequencer
  import sram_track_sequencer_pkg::*;
#(
  parameter int unsigned TRACK_LEN    = 128000,
  parameter int unsigned TRACK_B_BASE = 128000,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLRCK,
  input  logic [1:0]        iMODE,
  input  logic              iTRACK_SEL,
  input  logic [DATA_W-1:0] iREC_DATA,
  output logic [DATA_W-1:0] oPLAY_DATA,
  output logic              oPLAY_VALID,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_WDATA,
  output logic              oSRAM_DQ_OE,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  input  logic [DATA_W-1:0] iSRAM_RDATA,
  output logic              oBUSY,
  output logic              oMIX_DONE
);

  localparam int unsigned IDX_W = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TRACK_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
  logic              tick_q, tick_d, tick_clr;
  logic              armed_q, armed_d;
  mode_e             mode, mode_last_q, mode_last_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] play_data_q, play_data_d;
  logic              play_valid_q, play_valid_d;
  logic [2:0]        lrck_sync_q;
  logic              lrck_rise;

  logic              req, req_wr, acc_done;
  logic [ADDR_W-1:0] req_addr, addr_a, addr_b, addr_a_next;
  logic [DATA_W-1:0] req_wdata;

  assign mode        = mode_e'(iMODE);
  // [0],[1] synchronise, [2] holds the previous synchronised level for edge detection.
  assign lrck_rise   = lrck_sync_q[1] & ~lrck_sync_q[2];
  assign idx_next    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign addr_a      = ADDR_W'(TRACK_A_BASE) + ADDR_W'(idx_q);
  assign addr_b      = ADDR_W'(TRACK_B_BASE) + ADDR_W'(idx_q);
  assign addr_a_next = ADDR_W'(TRACK_A_BASE) + ADDR_W'(idx_next);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tick_clr     = 1'b0;
    armed_d      = armed_q | (mode != MODE_MIX);
    mode_last_d  = mode_last_q;
    a_d          = a_q;
    b_d          = b_q;
    play_data_d  = play_data_q;
    play_valid_d = 1'b0;
    req          = 1'b0;
    req_wr       = 1'b0;
    req_addr     = addr_a;
    req_wdata    = iREC_DATA;

    unique case (state_q)
      StIdle: begin
        mode_last_d = mode;
        if (mode != mode_last_q) begin
          idx_d    = '0;
          tick_clr = 1'b1;
        end else begin
          unique case (mode)
            MODE_REC: if (tick_q) begin
              req      = 1'b1;
              req_wr   = 1'b1;
              req_addr = iTRACK_SEL ? addr_b : addr_a;
              state_d  = StRecWr;
            end
            MODE_PLAY: if (tick_q) begin
              req     = 1'b1;
              state_d = StPlayRdA;
            end
            MODE_MIX: if (armed_q) begin
              idx_d    = '0;
              req      = 1'b1;
              req_addr = ADDR_W'(TRACK_A_BASE);
              state_d  = StMixRdA;
            end
            MODE_IDLE: ;
          endcase
        end
      end
      StRecWr: if (acc_done) begin
        tick_clr = 1'b1;
        idx_d    = idx_next;
        state_d  = StIdle;
      end
      StPlayRdA: if (acc_done) begin
        a_d      = iSRAM_RDATA;
        req      = 1'b1;
        req_addr = addr_b;
        state_d  = StPlayRdB;
      end
      StPlayRdB: if (acc_done) begin
        b_d     = iSRAM_RDATA;
        state_d = StPlayOut;
      end
      StPlayOut: begin
        play_data_d  = avg(a_q, b_q);
        play_valid_d = 1'b1;
        tick_clr     = 1'b1;
        idx_d        = idx_next;
        state_d      = StIdle;
      end
      StMixRdA: if (acc_done) begin
        a_d      = iSRAM_RDATA;
        req      = 1'b1;
        req_addr = addr_b;
        state_d  = StMixRdB;
      end
      StMixRdB: if (acc_done) begin
        req       = 1'b1;
        req_wr    = 1'b1;
        req_addr  = addr_a;
        req_wdata = avg(a_q, iSRAM_RDATA);
        state_d   = StMixWr;
      end
      StMixWr: if (acc_done) begin
        if (idx_q == IDX_LAST) begin
          state_d = StMixEnd;
        end else begin
          idx_d    = idx_next;
          req      = 1'b1;
          req_addr = addr_a_next;
          state_d  = StMixRdA;
        end
      end
      StMixEnd: begin
        armed_d  = 1'b0;
        idx_d    = '0;
        tick_clr = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A tick arriving while one is still pending is dropped, including on its clear cycle.
    tick_d = tick_clr ? 1'b0 : tick_q;
    if (lrck_rise && !tick_q) tick_d = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tick_q       <= 1'b0;
      armed_q      <= 1'b1;
      mode_last_q  <= MODE_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
      lrck_sync_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      armed_q      <= armed_d;
      mode_last_q  <= mode_last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      play_data_q  <= play_data_d;
      play_valid_q <= play_valid_d;
      lrck_sync_q  <= {lrck_sync_q[1:0], iLRCK};
    end
  end

  sram_access_timer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_access (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iREQ        (req),
    .iWR         (req_wr),
    .iADDR       (req_addr),
    .iWDATA      (req_wdata),
    .oDONE       (acc_done),
    .oSRAM_ADDR  (oSRAM_ADDR),
    .oSRAM_WDATA (oSRAM_WDATA),
    .oSRAM_DQ_OE (oSRAM_DQ_OE),
    .oSRAM_WE_N  (oSRAM_WE_N),
    .oSRAM_OE_N  (oSRAM_OE_N)
  );

  assign oPLAY_DATA  = play_data_q;
  assign oPLAY_VALID = play_valid_q;
  assign oBUSY       = (state_q != StIdle);
  assign oMIX_DONE   = (state_q == StMixEnd);

endmodule

// File: tb/tb_sram_track_sequencer.sv
// Directed bench for sram_track_sequencer with a behavioural SRAM and a short track length.
module tb_sram_track_sequencer;

  localparam int unsigned TL = 4;
  localparam int unsigned BB = 128000;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iLRCK = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic        iTRACK_SEL = 1'b0;
  logic [15:0] iREC_DATA = 16'h0;
  logic [15:0] iSRAM_RDATA = 16'h0;
  logic [15:0] oPLAY_DATA, oSRAM_WDATA;
  logic [17:0] oSRAM_ADDR;
  logic        oPLAY_VALID, oSRAM_DQ_OE, oSRAM_WE_N, oSRAM_OE_N, oBUSY, oMIX_DONE;

  always #10 iCLK = ~iCLK;

  sram_track_sequencer #(
    .TRACK_LEN    (TL),
    .TRACK_B_BASE (BB),
    .ADDR_W       (18),
    .DATA_W       (16)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iLRCK       (iLRCK),
    .iMODE       (iMODE),
    .iTRACK_SEL  (iTRACK_SEL),
    .iREC_DATA   (iREC_DATA),
    .oPLAY_DATA  (oPLAY_DATA),
    .oPLAY_VALID (oPLAY_VALID),
    .oSRAM_ADDR  (oSRAM_ADDR),
    .oSRAM_WDATA (oSRAM_WDATA),
    .oSRAM_DQ_OE (oSRAM_DQ_OE),
    .oSRAM_WE_N  (oSRAM_WE_N),
    .oSRAM_OE_N  (oSRAM_OE_N),
    .iSRAM_RDATA (iSRAM_RDATA),
    .oBUSY       (oBUSY),
    .oMIX_DONE   (oMIX_DONE)
  );

  // Behavioural SRAM plus access/pulse logging, all sampled on the falling edge.
  logic [15:0] mem [0:262143];
  logic        poke_en = 1'b0;
  logic [17:0] poke_addr = '0;
  logic [15:0] poke_data = '0;
  int unsigned wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int unsigned rd_addr_log[$];
  logic        rd_phase = 1'b0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  int          proto_err = 0;

  always @(negedge iCLK) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (!oSRAM_WE_N) begin
      mem[oSRAM_ADDR] <= oSRAM_WDATA;
      wr_addr_log.push_back(int'(oSRAM_ADDR));
      wr_data_log.push_back(oSRAM_WDATA);
    end
    if (!oSRAM_OE_N) begin
      iSRAM_RDATA <= mem[oSRAM_ADDR];
      if (!rd_phase) rd_addr_log.push_back(int'(oSRAM_ADDR));
      rd_phase <= !rd_phase;
    end else begin
      iSRAM_RDATA <= 16'h0;
      rd_phase    <= 1'b0;
    end
    if (oPLAY_VALID) valid_cnt <= valid_cnt + 1;
    if (oMIX_DONE) done_cnt <= done_cnt + 1;
    if ((!oSRAM_WE_N && !oSRAM_DQ_OE) || (!oSRAM_OE_N && oSRAM_DQ_OE)) proto_err <= proto_err + 1;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } avg_vec_t;

  avg_vec_t play_tbl[4];
  avg_vec_t mix_tbl[4];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic frame();
    iLRCK = 1'b1;
    cycles(16);
    iLRCK = 1'b0;
    cycles(16);
  endtask

  task automatic set_mode(input logic [1:0] m);
    iMODE = m;
    cycles(3);
  endtask

  task automatic poke(input int unsigned addr, input logic [15:0] data);
    poke_addr = 18'(addr);
    poke_data = data;
    poke_en   = 1'b1;
    @(negedge iCLK);
    #1 poke_en = 1'b0;
  endtask

  initial begin
    int base, rb, v0, d0;
    bit seen;

    play_tbl[0] = '{16'h4000, 16'h2000, 16'h3000};
    play_tbl[1] = '{16'h8000, 16'h8000, 16'h8000};
    play_tbl[2] = '{16'h7FFF, 16'h0001, 16'h4000};
    play_tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    mix_tbl[0]  = '{16'd10,   16'd20,   16'd15};
    mix_tbl[1]  = '{16'hFFF6, 16'hFFEC, 16'hFFF1};
    mix_tbl[2]  = '{16'd100,  16'hFF9D, 16'd0};
    mix_tbl[3]  = '{16'd0,    16'd1,    16'd0};

    // Reset state
    cycles(3);
    check("rst_we_n", oSRAM_WE_N, 1);
    check("rst_oe_n", oSRAM_OE_N, 1);
    check("rst_dq_oe", oSRAM_DQ_OE, 0);
    check("rst_addr", oSRAM_ADDR, 0);
    check("rst_wdata", oSRAM_WDATA, 0);
    check("rst_play_data", oPLAY_DATA, 0);
    check("rst_play_valid", oPLAY_VALID, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_mix_done", oMIX_DONE, 0);
    iRST_N = 1'b1;
    cycles(3);

    // Record three frames into track A
    iTRACK_SEL = 1'b0;
    set_mode(2'd1);
    base = wr_addr_log.size();
    for (int i = 0; i < 3; i++) begin
      iREC_DATA = 16'(17 * (i + 1));
      frame();
    end
    check("rec_write_count", wr_addr_log.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rec_addr%0d", i), wr_addr_log[base+i], i);
      check($sformatf("rec_data%0d", i), wr_data_log[base+i], 17 * (i + 1));
    end

    // Switch to track B through idle: index restarts
    iTRACK_SEL = 1'b1;
    set_mode(2'd0);
    set_mode(2'd1);
    iREC_DATA = 16'h0044;
    base = wr_addr_log.size();
    frame();
    check("recb_write_count", wr_addr_log.size() - base, 1);
    check("recb_addr", wr_addr_log[base], BB);
    check("recb_data", wr_data_log[base], 16'h0044);

    // Playback averaging vectors
    set_mode(2'd0);
    for (int i = 0; i < 4; i++) begin
      poke(i, play_tbl[i].a);
      poke(BB + i, play_tbl[i].b);
    end
    set_mode(2'd2);
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      frame();
      check($sformatf("play%0d_valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("play%0d_data", i), oPLAY_DATA, play_tbl[i].exp);
    end

    // Index wrap over six frames
    set_mode(2'd0);
    set_mode(2'd2);
    rb = rd_addr_log.size();
    v0 = valid_cnt;
    for (int k = 0; k < 6; k++) frame();
    check("wrap_valid_pulses", valid_cnt - v0, 6);
    check("wrap_read_count", rd_addr_log.size() - rb, 12);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("wrap_rd_a%0d", k), rd_addr_log[rb+2*k], k % TL);
      check($sformatf("wrap_rd_b%0d", k), rd_addr_log[rb+2*k+1], BB + (k % TL));
    end

    // Second edge during service is dropped
    v0 = valid_cnt;
    iLRCK = 1'b1;
    cycles(2);
    iLRCK = 1'b0;
    cycles(2);
    iLRCK = 1'b1;
    cycles(40);
    iLRCK = 1'b0;
    cycles(40);
    check("double_edge_pulses", valid_cnt - v0, 1);

    // Mix pass, then hold mode 3
    set_mode(2'd0);
    for (int i = 0; i < 4; i++) begin
      poke(i, mix_tbl[i].a);
      poke(BB + i, mix_tbl[i].b);
    end
    d0 = done_cnt;
    base = wr_addr_log.size();
    iMODE = 2'd3;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      cycles(1);
      seen = (done_cnt != d0);
    end
    check("mix1_done_seen", seen, 1);
    cycles(100);
    check("mix1_done_pulses", done_cnt - d0, 1);
    check("mix1_write_count", wr_addr_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check($sformatf("mix1_a%0d", i), mem[i], mix_tbl[i].exp);

    // Mix with mode change and LRCK activity mid-pass
    set_mode(2'd0);
    d0 = done_cnt;
    base = wr_addr_log.size();
    rb = rd_addr_log.size();
    iMODE = 2'd3;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      cycles(1);
      seen = oBUSY;
    end
    check("mix2_started", seen, 1);
    iMODE = 2'd2;
    for (int k = 0; k < 3; k++) begin
      iLRCK = 1'b1;
      cycles(3);
      iLRCK = 1'b0;
      cycles(3);
    end
    seen = (done_cnt != d0);
    for (int t = 0; t < 200 && !seen; t++) begin
      cycles(1);
      seen = (done_cnt != d0);
    end
    check("mix2_done_seen", seen, 1);
    cycles(5);
    check("mix2_write_count", wr_addr_log.size() - base, 4);
    check("mix2_read_count", rd_addr_log.size() - rb, 8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mix2_wr_addr%0d", i), wr_addr_log[base+i], i);
      check($sformatf("mix2_rd_a%0d", i), rd_addr_log[rb+2*i], i);
      check($sformatf("mix2_rd_b%0d", i), rd_addr_log[rb+2*i+1], BB + i);
    end
    check("mix2_a0", mem[0], 16'd17);
    rb = rd_addr_log.size();
    v0 = valid_cnt;
    frame();
    check("post_mix_valid", valid_cnt - v0, 1);
    check("post_mix_rd_a", rd_addr_log[rb], 0);
    check("post_mix_data", oPLAY_DATA, 16'h0012);

    // Asynchronous reset during the write strobe
    set_mode(2'd1);
    iLRCK = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      cycles(1);
      seen = !oSRAM_WE_N;
    end
    check("strobe_seen", seen, 1);
    #3 iRST_N = 1'b0;
    #1;
    check("abort_we_n", oSRAM_WE_N, 1);
    check("abort_dq_oe", oSRAM_DQ_OE, 0);
    check("abort_oe_n", oSRAM_OE_N, 1);
    check("abort_addr", oSRAM_ADDR, 0);
    check("abort_busy", oBUSY, 0);
    check("abort_play_data", oPLAY_DATA, 0);
    iLRCK = 1'b0;
    cycles(2);
    iRST_N = 1'b1;
    cycles(3);

    check("bus_protocol_violations", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_track_sequencer.md
Name: sram_track_sequencer

Overview:
Owns the single 256K x 16 board SRAM and sequences every access to it for the two-track audio recorder. It records codec samples into track A or B, plays both tracks back as one averaged stream, and runs an offline mix pass that writes (A+B)/2 over track A. It sits between the audio_converter sample registers and the SRAM pins, and replaces the free-running address counters and direct SRAM_WE_N switching.

Parameters:
TRACK_LEN, 128000, samples per track; frame index range 0..TRACK_LEN-1
TRACK_B_BASE, 128000, SRAM base address of track B; track A base is 0
ADDR_W, 18, SRAM address width
DATA_W, 16, sample width, signed two's complement

Ports:
iCLK  in  1  50 MHz system clock
iRST_N  in  1  asynchronous active-low reset
iLRCK  in  1  codec DAC LR clock, asynchronous to iCLK; rising edge = one frame
iMODE  in  2  0 idle, 1 record, 2 play, 3 mix
iTRACK_SEL  in  1  record target: 0 track A, 1 track B
iREC_DATA  in  DATA_W  sample to record, stable across the frame
oPLAY_DATA  out  DATA_W  averaged playback sample
oPLAY_VALID  out  1  one-cycle pulse when oPLAY_DATA updates
oSRAM_ADDR  out  ADDR_W  SRAM address
oSRAM_WDATA  out  DATA_W  write data
oSRAM_DQ_OE  out  1  1 = top level drives SRAM_DQ with oSRAM_WDATA
oSRAM_WE_N  out  1  SRAM write strobe
oSRAM_OE_N  out  1  SRAM output enable
iSRAM_RDATA  in  DATA_W  SRAM_DQ read value
oBUSY  out  1  high whenever state != IDLE
oMIX_DONE  out  1  one-cycle pulse at the end of a mix pass

Behaviour:
- Reset values: oSRAM_WE_N=1, oSRAM_OE_N=1, oSRAM_DQ_OE=0, oSRAM_ADDR=0, oSRAM_WDATA=0, oPLAY_DATA=0, oPLAY_VALID=0, oBUSY=0, oMIX_DONE=0, idx=0, state=IDLE, tick_pend=0.
- iLRCK passes through a 2-flop synchroniser. A rising edge sets tick_pend.
- If tick_pend is already set when a new rising edge arrives, the new tick is dropped.
- In IDLE, a change of iMODE since the last IDLE cycle clears idx to 0 and clears tick_pend.
- Read access takes 2 cycles: cycle 1 drives addr with OE_N=0; cycle 2 holds and captures iSRAM_RDATA at its end.
- Write access takes 3 cycles with DQ_OE=1 throughout: setup (WE_N=1), strobe (WE_N=0), hold (WE_N=1). Address and data are stable across all 3 cycles.
- States: IDLE, REC_WR, PLAY_RDA, PLAY_RDB, PLAY_OUT, MIX_RDA, MIX_RDB, MIX_WR, MIX_END.
- IDLE, mode 1, tick_pend -> REC_WR.
  - Write iREC_DATA (sampled on entry) to base(iTRACK_SEL)+idx.
  - Clear tick_pend, advance idx, return to IDLE.
- IDLE, mode 2, tick_pend -> PLAY_RDA (read A[idx]) -> PLAY_RDB (read B[idx]) -> PLAY_OUT.
  - PLAY_OUT sets oPLAY_DATA=(sext(a)+sext(b))>>>1, using a 17-bit signed sum and arithmetic shift.
  - PLAY_OUT pulses oPLAY_VALID, clears tick_pend, advances idx, returns to IDLE.
- Mix start: mode 3 in IDLE, armed -> MIX_RDA with idx=0. The mixer is armed at reset and whenever iMODE != 3.
  - Loop: MIX_RDA -> MIX_RDB -> MIX_WR, which writes the average to A[idx].
  - If idx==TRACK_LEN-1 -> MIX_END; otherwise idx++ -> MIX_RDA.
  - MIX_END pulses oMIX_DONE, disarms, sets idx=0, returns to IDLE.
  - The mix runs at full clock rate and ignores ticks; tick_pend is cleared at MIX_END.
  - Changes to iMODE during the mix are ignored. Holding mode 3 after done does not retrigger.
- idx advance: TRACK_LEN-1 wraps to 0.
- Worst-case frame service is 6 cycles, far below one frame (~1042 cycles at 48 kHz).
- oSRAM_DQ_OE and oSRAM_WE_N are never low/high together outside a write access. WE_N=0 only occurs while DQ_OE=1.
- Asynchronous reset mid-access forces WE_N=1 and DQ_OE=0 immediately. An aborted write may leave that one word undefined.

Decomposition:
- Shared package: mode encodings (MODE_IDLE/REC/PLAY/MIX), state encoding, TRACK_A_BASE=0, and the average function (17-bit signed sum, >>>1).
- One sub-module: sram_access_timer. It takes a request pulse plus rd/wr, generates the 2/3-cycle OE_N/WE_N/DQ_OE timing, and returns a one-cycle done. The FSM waits on done.

Test Plan:
- Reset: assert iRST_N=0 mid-write (WE_N=0) -> WE_N=1 and DQ_OE=0 in the same cycle; all outputs at their reset values.
- Record: mode 1, sel 0, three LRCK edges with data 0x0011/0x0022/0x0033 -> writes at addr 0,1,2. Then sel 1 and mode 0 -> 1 -> next write at 128000 with the current data.
- Play averaging with A/B = 0x4000/0x2000 -> 0x3000. With 0x8000/0x8000 -> 0x8000. With 0x7FFF/0x0001 -> 0x4000. With 0xFFFF/0x0000 -> 0xFFFF. Each output comes with a single oPLAY_VALID pulse.
- Wrap: TRACK_LEN=4, play 6 frames -> read addresses A 0,1,2,3,0,1; no tick lost. Two LRCK edges within one service -> second edge dropped.
- Mix: TRACK_LEN=4, A={10,-10,100,0}, B={20,-20,-99,1} -> A={15,-15,0,0}; oMIX_DONE pulses once; holding mode 3 -> no second pass.
- LRCK toggling during mix -> no record/play access is interleaved; after MIX_END, mode 2 plays from idx 0.
